note_octave_decoder: RTL

NOTE_OCTAVE_DECODER -- requirements
Module: note_octave_decoder

---
 rtl/note_octave_decoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/note_octave_decoder.sv
// note_octave_decoder
//   Converts a 7-bit MIDI note number into an octave select and a semitone
//   index relative to BASE_NOTE. The division by 12 is done iteratively:
//   one subtraction of 12 per clock, so the latency is n+1 edges for n
//   subtractions. The octave/semitone/sat outputs are held registers that
//   only change on the edge that raises out_valid, so a downstream
//   octave-selectable divider never sees an intermediate value.
//
//   Optional feature macro: OCTAVE_WRAP_EN
//     undefined (default) : octave overflow saturates to octave 7,
//                           semitone 11, sat 1.
//     defined             : the octave counter wraps modulo 8, the semitone
//                           is the true remainder and sat flags the wrap.
module note_octave_decoder #(
    parameter int BASE_NOTE = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       note_valid,
    input  logic [6:0] note_num,
    output logic       note_ready,
    output logic [2:0] octave,
    output logic [3:0] semitone,
    output logic       out_valid,
    output logic       sat,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

    localparam logic [6:0] BASE_N  = 7'(BASE_NOTE);
    localparam logic [6:0] SEMI_12 = 7'd12;
    localparam logic [2:0] OCT_TOP = 3'd7;

    state_t     state;
    state_t     state_nxt;

    // Conversion working registers: remaining offset and octave count.
    logic [6:0] rem;
    logic [2:0] oct_cnt;
    logic       under;     // request was below BASE_NOTE
    logic       wrapped;   // octave counter passed 7 at least once

    logic       accept;
    logic       rem_ge12;
    logic       cap;       // octave limit reached, stop subtracting
    logic       step;
    logic       finish;
    logic       limit;     // finishing because of the octave cap

    // True when the note lies below the base note.
    function automatic logic below_base(input logic [6:0] n);
        return (n < BASE_N);
    endfunction

    // Offset from the base note, clamped at zero for under-range notes.
    function automatic logic [6:0] offset_from_base(input logic [6:0] n);
        return below_base(n) ? 7'd0 : (n - BASE_N);
    endfunction

    // Result octave: pinned to the top octave when the cap forced the finish.
    function automatic logic [2:0] sat_octave(input logic       lim,
                                              input logic [2:0] oct);
        return lim ? OCT_TOP : oct;
    endfunction

    // Result semitone: pinned to the top semitone when the cap forced the finish.
    function automatic logic [3:0] sat_semitone(input logic       lim,
                                                input logic [6:0] r);
        return lim ? 4'd11 : r[3:0];
    endfunction

    assign note_ready = (state == IDLE) && !reset;
    assign busy       = (state == DIV);
    assign accept     = note_valid && note_ready;
    assign rem_ge12   = (rem >= SEMI_12);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle datapath controls.
    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        finish    = 1'b0;
        limit     = 1'b0;
`ifdef OCTAVE_WRAP_EN
        cap       = 1'b0;
`else
        cap       = (oct_cnt == OCT_TOP);
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = DIV;
                end
            end
            DIV: begin
                if (rem_ge12 && !cap) begin
                    step = 1'b1;
                end else begin
                    finish    = 1'b1;
                    limit     = rem_ge12;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Working registers: load on acceptance, subtract 12 per step.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem     <= offset_from_base(note_num);
            under   <= below_base(note_num);
            oct_cnt <= 3'd0;
            wrapped <= 1'b0;
        end else if (step) begin
            rem     <= rem - SEMI_12;
            oct_cnt <= oct_cnt + 3'd1;
            wrapped <= wrapped | (oct_cnt == OCT_TOP);
        end
    end

    // Held result registers and the one-cycle completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            octave    <= 3'd0;
            semitone  <= 4'd0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= finish;
            if (finish) begin
                octave   <= sat_octave(limit, oct_cnt);
                semitone <= sat_semitone(limit, rem);
                sat      <= under | wrapped | limit;
            end
        end
    end

endmodule
